// File: rtl/game_pkg.sv
// Shared game definitions: move direction codes, input FSM states and the
// press-priority helper used by the move input controller.
package game_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        VALID,
        RELEASE
    } move_state_t;

    // Up wins over left, left over down, down over right.
    function automatic logic [1:0] pick_dir(input logic [3:0] rise);
        if (rise[0]) begin
            return DIR_UP;
        end else if (rise[1]) begin
            return DIR_LEFT;
        end else if (rise[2]) begin
            return DIR_DOWN;
        end else begin
            return DIR_RIGHT;
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer followed by a consecutive-cycle
// debounce counter that toggles the accepted level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic synced
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            synced <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
        end else begin
            meta   <= btn;
            synced <= meta;
            if (synced != level) begin
                if (cnt == LAST) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/move_input_ctrl.sv
// Turns four debounced buttons into one valid/ready move per press.
// Define MOVE_INPUT_REPEAT_EN to add auto-repeat while the move button is held.
module move_input_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       move_ready,
    output logic [1:0] dir,
    output logic       move_valid,
    output logic [3:0] btn_state
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_bad_cfg
        $error("move_input_ctrl: cycle parameters out of range");
    end

    logic [3:0]  level;
    logic [3:0]  synced;
    logic [3:0]  prev;
    logic [3:0]  rise;
    logic [1:0]  fill;
    logic        armed;
    logic        rep_hit;
    logic [1:0]  dir_nx;
    move_state_t state;
    move_state_t state_nx;

    for (genvar i = 0; i < 4; i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn[i]),
            .level (level[i]),
            .synced(synced[i])
        );
    end

    assign btn_state = level;

    // Presses are only honoured once every button has been seen released
    // after reset, so a button held through reset cannot fire a move.
    assign rise = level & ~prev & {4{armed}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dir   <= DIR_UP;
            prev  <= '0;
            fill  <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_nx;
            dir   <= dir_nx;
            prev  <= level;
            fill  <= {fill[0], 1'b1};
            if (fill[1] && synced == '0 && level == '0) begin
                armed <= 1'b1;
            end
        end
    end

`ifdef MOVE_INPUT_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_hold;

    assign rep_hold = level[dir];
    assign rep_hit  = (state == RELEASE) && rep_hold && (rep_cnt == REP_LAST);

    // The handshake cycle counts as the first held cycle of the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt <= '0;
        end else if (state == VALID && move_ready) begin
            rep_cnt <= RW'(1);
        end else if (state == RELEASE && rep_hold && !rep_hit) begin
            rep_cnt <= rep_cnt + 1'b1;
        end else begin
            rep_cnt <= '0;
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        dir_nx     = dir;
        move_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (|rise) begin
                    dir_nx   = pick_dir(rise);
                    state_nx = VALID;
                end
            end
            VALID: begin
                move_valid = 1'b1;
                if (move_ready) begin
                    state_nx = RELEASE;
                end
            end
            RELEASE: begin
                if (level == '0) begin
                    state_nx = IDLE;
                end else if (rep_hit) begin
                    state_nx = VALID;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: doc/move_input_ctrl.md
MOVE_INPUT_CTRL -- requirements
Module: move_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the consecutive-cycle count a synchronized button level must hold to be accepted.
REQ-002 Parameter REPEAT_CYCLES, default 25000000, SHALL set the hold time before an auto-repeat move; it is used only under REQ-024.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 btn  input  4  SHALL be the raw asynchronous push-buttons: bit0 up, bit1 left, bit2 down, bit3 right; 1 = pressed.
REQ-006 move_ready  input  1  SHALL be asserted by the downstream game controller when it can accept a move.
REQ-007 dir  output  2  SHALL be the move direction: 00 up, 01 left, 10 down, 11 right.
REQ-008 move_valid  output  1  SHALL mark dir as a pending move request.
REQ-009 btn_state  output  4  SHALL be the debounced button levels, for debug display.

Function
REQ-010 Each btn bit SHALL pass through a 2-flop synchronizer before debouncing.
REQ-011 Per button, the counter SHALL increment while the synchronized level differs from the debounced level, and clear when they match.
REQ-012 The debounced level SHALL toggle, and the counter SHALL clear, on the cycle the counter reaches DEBOUNCE_CYCLES-1.
REQ-013 The counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter never wraps.
REQ-014 FSM states SHALL be IDLE, VALID and RELEASE.
REQ-015 In IDLE, on the first cycle one or more debounced bits rise, dir SHALL latch the highest-priority new press (up > left > down > right) and the FSM SHALL enter VALID.
REQ-016 In VALID, move_valid SHALL be 1 and dir SHALL stay constant until the cycle move_valid && move_ready.
REQ-017 On that handshake cycle the FSM SHALL enter RELEASE, and move_valid SHALL be 0 from the next cycle.
REQ-018 In RELEASE, new presses SHALL be ignored; when btn_state == 0 the FSM SHALL return to IDLE.
REQ-019 A button already held when the FSM enters IDLE SHALL NOT generate a move; only a rising debounced edge does.
REQ-020 Exactly one move SHALL be issued per press.
REQ-021 Latency from a clean press at btn to move_valid SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles, independent of move_ready.
REQ-022 Simultaneous presses SHALL be resolved per REQ-015; lower-priority presses SHALL be dropped, not queued.

Reset
REQ-023 While rst is 1: synchronizers, debounced levels and counters SHALL clear to 0; FSM SHALL enter IDLE; dir = 00, move_valid = 0, btn_state = 0. A pending VALID SHALL be discarded. A button still held after reset SHALL NOT issue a move until it is released and pressed again.

Configuration
REQ-024 With macro MOVE_INPUT_REPEAT_EN defined, an added counter SHALL run in RELEASE while the button that produced the last move stays held. When it reaches REPEAT_CYCLES-1, the FSM SHALL re-enter VALID with the same dir, and the counter SHALL clear on any release.
REQ-025 Without MOVE_INPUT_REPEAT_EN, the repeat counter and its logic SHALL be absent, and behaviour SHALL be exactly REQ-014..REQ-022.

Structure
REQ-026 The shared package game_pkg SHALL hold the 2-bit direction constants (DIR_UP, DIR_LEFT, DIR_DOWN, DIR_RIGHT) and the FSM state typedef; the game controller SHALL import the same direction constants.
REQ-027 Synchronizer plus debounce SHALL be a sub-module btn_debounce, instantiated four times; the FSM and priority encode SHALL live in move_input_ctrl.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
REQ-028 Single press: hold btn=0100 with move_ready=1 -> move_valid=1, dir=10 exactly 7 cycles after the press, for 1 cycle; no further move until release.
REQ-029 Bounce: toggle btn[0] every 2 cycles for 20 cycles, then hold 0 -> btn_state stays 0000 and move_valid is never 1.
REQ-030 Backpressure: press right with move_ready=0 for 10 cycles, then 1 -> move_valid is held, dir=11 is stable throughout, and the handshake completes exactly once.
REQ-031 Simultaneous press: btn 0000->1010 -> dir=01 (left); after release and a press of btn=1000 -> dir=11.
REQ-032 Reset mid-VALID: assert rst while move_valid=1 and the button is held -> outputs are 0 the next cycle, and no move is issued until re-press.
REQ-033 With MOVE_INPUT_REPEAT_EN: hold up with move_ready=1 -> moves at press+7, then every 8 cycles; without the macro, only the first move occurs.
